bridge_arbiter: RTL
===================

# bridge_arbiter

Two-master, one-slave arbiter for the 16-bit external bus bridge protocol. It lets the two Avalon-to-external bus bridges in the Nios system (bridge0, bridge1) share a single external slave, such as a register bank or SRAM controller. Round-robin grant, one transaction in flight, registered slave-side outputs. Acknowledge and read data are returned only to the owning master.

## Interface
Parameters:
- ADDR_W, 11, address width
- DATA_W, 16, data width
- BE_W, 2, byte-enable width
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with the timeout feature)

Ports:
- clk_clk  in  1  system clock; all logic on its rising edge
- reset_reset_n  in  1  asynchronous, active-low reset
- mN_address  in  ADDR_W  master N address (N = 0, 1)
- mN_bus_enable  in  1  master N request; held until acknowledged
- mN_byte_enable  in  BE_W  master N byte lanes
- mN_rw  in  1  master N direction; 1 = read, 0 = write
- mN_write_data  in  DATA_W  master N write data
- mN_read_data  out  DATA_W  read data to master N
- mN_acknowledge  out  1  one-cycle completion pulse to master N
- mN_irq  out  1  slave interrupt, forwarded to master N
- s_address / s_byte_enable / s_rw / s_write_data  out  ADDR_W / BE_W / 1 / DATA_W  to slave
- s_bus_enable  out  1  slave request
- s_read_data  in  DATA_W  slave read data
- s_acknowledge  in  1  slave completion pulse
- s_irq  in  1  slave interrupt
- grant  out  2  one-hot current owner; 0 when idle
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a transaction

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any mN_bus_enable is high, choose the winner.
  - One requester: that master wins.
  - Both requesting: the master not granted last wins. last_grant resets to 1, so m0 wins the first tie.
  - On the winner, latch address, byte_enable, rw and write_data into slave-side registers, set owner and grant, then go to BUSY.
- BUSY:
  - s_bus_enable = 1 and slave outputs come from the latched registers.
  - Changes on master inputs are ignored until DONE.
  - On s_acknowledge: capture s_read_data into the owner's read-data register, drop s_bus_enable, go to DONE.
- DONE:
  - Pulse the owner's mN_acknowledge for exactly one cycle.
  - Update last_grant to the owner, clear grant, go to IDLE.
- The non-owner's acknowledge stays 0 throughout. Its read_data holds its previous value.
- mN_irq = s_irq registered by one flop, driven to both masters.
- Reset (asynchronous, any state): FSM to IDLE. All outputs go to 0 immediately: s_* outputs, mN_read_data, mN_acknowledge, mN_irq, grant, timeout_err. last_grant goes to 1. An aborted transaction is not replayed.
- s_acknowledge outside BUSY is ignored.

## Timing
- Request sampled at edge E0 → grant and s_bus_enable high after E0 (1 cycle).
- Slave ack sampled at edge Ek → state DONE; mN_acknowledge and mN_read_data valid for the cycle after Ek+1. Turnaround is 2 cycles from slave ack to master ack.
- The DONE→IDLE cycle lets the master drop bus_enable, so a stale request is never regranted.
- Minimum back-to-back spacing is 4 cycles per transaction with a zero-wait slave: IDLE, BUSY, DONE, IDLE.
- Alternating tie: with both requests held continuously, grants go m0, m1, m0, …

## Configuration
- BRIDGE_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC with no s_acknowledge: drop s_bus_enable, load 16'hDEAD into the owner's read data, pulse timeout_err with the DONE-state acknowledge, then follow the normal DONE path.
  - An ack arriving on the same edge as the limit wins: normal completion, no error.
- Macro undefined: no counter; BUSY waits indefinitely; timeout_err is tied to 0.

## Structure
- Package bridge_arb_pkg holds:
  - the state enum (IDLE, BUSY, DONE)
  - TIMEOUT_DATA = 16'hDEAD
  - default width constants
- One sub-module, bridge_arb_timer: loadable cycle counter with a terminal-count flag, instantiated only under BRIDGE_ARB_TIMEOUT_EN.

## Test plan
- m0 write addr 11'h010, data 16'h1234, be 2'b11; slave acks 3 cycles later → s_* match; m0_acknowledge pulses once; m1_acknowledge stays 0.
- m0 and m1 request in the same cycle, both held → grants m0, m1, m0; grant stays one-hot; slave sees each master's address in turn.
- m1 read, slave returns 16'hBEEF → m1_read_data = 16'hBEEF on the m1_acknowledge cycle; m0_read_data unchanged.
- Reset asserted mid-BUSY → s_bus_enable and grant go 0 asynchronously; after release, a first tie goes to m0.
- With BRIDGE_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, slave never acks → abort after 8 BUSY cycles; owner receives 16'hDEAD and an acknowledge; timeout_err pulses once.
- s_irq toggles → m0_irq and m1_irq follow one cycle later.

Source files
------------

// File: rtl/bridge_arb_pkg.sv
// Shared types and constants for the two-master external bus bridge arbiter.
package bridge_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF      = 11;
  localparam int DATA_W_DEF      = 16;
  localparam int BE_W_DEF        = 2;
  localparam int TIMEOUT_CYC_DEF = 255;

  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/bridge_arb_timer.sv
// Loadable down-counter with a terminal-count flag; watchdog for a stalled slave.
module bridge_arb_timer #(
  parameter int W = 8
) (
  input  logic         clk_sys,
  input  logic         rst_b,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = en && (cnt == '0);

endmodule

// File: rtl/bridge_arbiter.sv
// Round-robin arbiter letting two bridge masters share one external slave.
// Optional watchdog abort is enabled by defining BRIDGE_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction; pick a winner among live requests
// BUSY  | slave request driven from latched registers, waiting for ack
// DONE  | completion; owner ack registered out, grant cleared
module bridge_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BE_W        = BE_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_bus_enable,
  input  logic [BE_W-1:0]   m0_byte_enable,
  input  logic              m0_rw,
  input  logic [DATA_W-1:0] m0_write_data,
  output logic [DATA_W-1:0] m0_read_data,
  output logic              m0_acknowledge,
  output logic              m0_irq,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_bus_enable,
  input  logic [BE_W-1:0]   m1_byte_enable,
  input  logic              m1_rw,
  input  logic [DATA_W-1:0] m1_write_data,
  output logic [DATA_W-1:0] m1_read_data,
  output logic              m1_acknowledge,
  output logic              m1_irq,
  output logic [ADDR_W-1:0] s_address,
  output logic [BE_W-1:0]   s_byte_enable,
  output logic              s_rw,
  output logic [DATA_W-1:0] s_write_data,
  output logic              s_bus_enable,
  input  logic [DATA_W-1:0] s_read_data,
  input  logic              s_acknowledge,
  input  logic              s_irq,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  arb_state_t state, state_nxt;
  logic owner, last_grant;
  logic req0, req1;
  logic win_valid, win_id;
  logic complete, abort;
  logic tmr_tc;

  // A master whose ack is showing this cycle has not yet had a chance to drop
  // its request, so it is masked to avoid regranting a stale request.
  assign req0 = m0_bus_enable & ~m0_acknowledge;
  assign req1 = m1_bus_enable & ~m1_acknowledge;

  always_comb begin
    state_nxt = state;
    win_valid = 1'b0;
    win_id    = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          win_valid = 1'b1;
          win_id    = (req0 && req1) ? ~last_grant : req1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (s_acknowledge) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (tmr_tc) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state          <= IDLE;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      grant          <= 2'b00;
      s_address      <= '0;
      s_byte_enable  <= '0;
      s_rw           <= 1'b0;
      s_write_data   <= '0;
      s_bus_enable   <= 1'b0;
      m0_read_data   <= '0;
      m1_read_data   <= '0;
      m0_acknowledge <= 1'b0;
      m1_acknowledge <= 1'b0;
      m0_irq         <= 1'b0;
      m1_irq         <= 1'b0;
    end else begin
      state          <= state_nxt;
      m0_acknowledge <= 1'b0;
      m1_acknowledge <= 1'b0;
      m0_irq         <= s_irq;
      m1_irq         <= s_irq;
      if (win_valid) begin
        owner         <= win_id;
        grant         <= win_id ? 2'b10 : 2'b01;
        s_address     <= win_id ? m1_address : m0_address;
        s_byte_enable <= win_id ? m1_byte_enable : m0_byte_enable;
        s_rw          <= win_id ? m1_rw : m0_rw;
        s_write_data  <= win_id ? m1_write_data : m0_write_data;
        s_bus_enable  <= 1'b1;
      end
      if (complete || abort) begin
        s_bus_enable <= 1'b0;
        if (owner) m1_read_data <= complete ? s_read_data : DATA_W'(TIMEOUT_DATA);
        else       m0_read_data <= complete ? s_read_data : DATA_W'(TIMEOUT_DATA);
      end
      if (state == DONE) begin
        last_grant <= owner;
        grant      <= 2'b00;
        if (owner) m1_acknowledge <= 1'b1;
        else       m0_acknowledge <= 1'b1;
      end
    end
  end

`ifdef BRIDGE_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic timed_out;

  // Loaded with limit-1 so terminal count lands on the last allowed BUSY cycle.
  bridge_arb_timer #(.W(TMR_W)) u_timer (
    .clk_sys  (clk_clk),
    .rst_b    (reset_reset_n),
    .load     (win_valid),
    .en       (state == BUSY),
    .load_val (TMR_W'(TIMEOUT_CYC - 1)),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      timed_out   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (abort)          timed_out <= 1'b1;
      else if (win_valid) timed_out <= 1'b0;
      if (state == DONE)  timeout_err <= timed_out;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign tmr_tc      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
